// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and default sizes for the multi-channel PWM
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam int PWM_WIDTH    = 8;
  localparam int PWM_CHANNELS = 4;

endpackage

// File: rtl/pwm_counter.sv
// rtl/pwm_counter.sv - period counter for edge/center alignment with boundary detect
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  pwm_mode_e        mode,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             boundary
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             up;
  logic             up_next;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = '0;
    up_next    = 1'b1;
    if (en && period != '0) begin
      if (mode == PWM_EDGE) begin
        if (count < period) count_next = count + ONE;
      end else if (up) begin
        if (count < period) begin
          count_next = count + ONE;
        end else if (period != ONE) begin
          // top reached: turn around; a period of 1 wraps straight to 0
          count_next = period - ONE;
          up_next    = 1'b0;
        end
      end else if (count > ONE) begin
        count_next = count - ONE;
        up_next    = 1'b0;
      end
    end
  end

  // a disabled counter treats every cycle as a boundary so loads land at once
  assign boundary = ~en | (count_next == '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
      up    <= 1'b1;
    end else begin
      count <= count_next;
      up    <= up_next;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shadowed period/duty/mode reloaded at boundaries
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH,
  parameter int CHANNELS = PWM_CHANNELS
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm_o,
  output logic                      cycle_start,
  output logic                      load_ack
);

  pwm_mode_e                 mode_a, mode_p;
  logic [WIDTH-1:0]          period_a, period_p;
  logic [CHANNELS*WIDTH-1:0] duty_a, duty_p;
  logic                      pend_v;
  logic [WIDTH-1:0]          count;
  logic                      boundary;

  pwm_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .en       (en),
    .mode     (mode_a),
    .period   (period_a),
    .count    (count),
    .boundary (boundary)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_a   <= PWM_EDGE;
      period_a <= '1;
      duty_a   <= '0;
      mode_p   <= PWM_EDGE;
      period_p <= '0;
      duty_p   <= '0;
      pend_v   <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      if (boundary) begin
        // a load in the boundary cycle wins over anything already pending
        if (load) begin
          mode_a   <= pwm_mode_e'(mode);
          period_a <= period;
          duty_a   <= duty;
        end else if (pend_v) begin
          mode_a   <= mode_p;
          period_a <= period_p;
          duty_a   <= duty_p;
        end
        pend_v   <= 1'b0;
        load_ack <= load | pend_v;
      end else if (load) begin
        mode_p   <= pwm_mode_e'(mode);
        period_p <= period;
        duty_p   <= duty;
        pend_v   <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
    assign pwm_o[i] = en & (count < duty_a[i*WIDTH +: WIDTH]);
  end

  assign cycle_start = n_rst & en & (count == '0);

endmodule
